seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl_pkg.sv | 38 +++
 rtl/seg_scan_ctrl_lut.sv | 20 ++
 rtl/seg_scan_ctrl.sv | 104 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared segment encodings for the RPM display path.
// Active-high segments: bit0=a .. bit6=g, bit7=dp.
package seg_scan_ctrl_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

  // Non-decimal nibbles render as a dash so a bad upstream value is visible.
  function automatic logic [7:0] digit_seg(input logic [3:0] digit);
    logic [7:0] s;
    case (digit)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_lut.sv
// Digit-to-segment lookup with dash and blank overrides; dash wins over blank.
module seg_lut
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [7:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (dash) begin
      seg_c = SEG_DASH;
    end else if (!blank) begin
      seg_c = digit_seg(digit);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner with periodic snapshot, leading-zero
// blanking, per-slot dark gap and overflow dash.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned BLANK_GAP   = 2,
  parameter int unsigned HOLD_SCANS  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dec0,
  input  logic [3:0] dec1,
  input  logic [3:0] dec2,
  input  logic [3:0] dec3,
  input  logic       ovf,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame
);

  localparam int unsigned PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SCAN_W = (HOLD_SCANS > 1) ? $clog2(HOLD_SCANS) : 1;

  logic [PRE_W-1:0]  presc;
  logic [1:0]        idx;
  logic [SCAN_W-1:0] scan_cnt;
  logic [3:0][3:0]   snap_dig;
  logic              snap_ovf;
  logic              load_pending;

  logic              slot_end_c;
  logic              scan_end_c;
  logic              load_c;
  logic              in_gap_c;
  logic              blank_c;
  logic [3:0]        cur_dig_c;
  logic [7:0]        lut_seg_c;

  // Sequencing conditions derived from the current counter state.
  always_comb begin
    slot_end_c = (presc == PRE_W'(REFRESH_DIV - 1));
    scan_end_c = slot_end_c && (idx == 2'd3);
    load_c     = load_pending ||
                 (scan_end_c && (scan_cnt == SCAN_W'(HOLD_SCANS - 1)));
    in_gap_c   = (presc < PRE_W'(BLANK_GAP));
  end

  // A digit is a leading zero when it and every more significant digit are 0.
  always_comb begin
    cur_dig_c = snap_dig[idx];
    blank_c   = 1'b0;
    case (idx)
      2'd1:    blank_c = (snap_dig[3:1] == 12'd0);
      2'd2:    blank_c = (snap_dig[3:2] == 8'd0);
      2'd3:    blank_c = (snap_dig[3] == 4'd0);
      default: blank_c = 1'b0;
    endcase
  end

  seg_lut u_lut (
    .digit (cur_dig_c),
    .blank (blank_c),
    .dash  (snap_ovf),
    .seg_c (lut_seg_c)
  );

  // Counters, snapshot and registered outputs; outputs use pre-edge state.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc        <= '0;
      idx          <= 2'd0;
      scan_cnt     <= '0;
      snap_dig     <= '0;
      snap_ovf     <= 1'b0;
      load_pending <= 1'b1;
      seg          <= SEG_BLANK;
      an           <= 4'd0;
      frame        <= 1'b0;
    end else begin
      presc <= slot_end_c ? '0 : presc + PRE_W'(1);
      if (slot_end_c) begin
        idx <= idx + 2'd1;
      end
      if (scan_end_c) begin
        scan_cnt <= (scan_cnt == SCAN_W'(HOLD_SCANS - 1)) ? '0 : scan_cnt + SCAN_W'(1);
      end
      frame <= load_c;
      if (load_c) begin
        snap_dig     <= {dec3, dec2, dec1, dec0};
        snap_ovf     <= ovf;
        load_pending <= 1'b0;
      end
      if (in_gap_c) begin
        an  <= 4'd0;
        seg <= SEG_BLANK;
      end else begin
        an  <= 4'(1) << idx;
        seg <= lut_seg_c;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic model of the scan timeline.
module tb_seg_scan_ctrl;

  localparam int RD   = 8;
  localparam int GAP  = 2;
  localparam int HOLD = 2;
  localparam int PERIOD = RD * 4 * HOLD;

  logic       clk;
  logic       reset;
  logic [3:0] dec0, dec1, dec2, dec3;
  logic       ovf;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame;

  int tests;
  int fails;
  int cyc;

  seg_scan_ctrl #(
    .REFRESH_DIV (RD),
    .BLANK_GAP   (GAP),
    .HOLD_SCANS  (HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dec0  (dec0),
    .dec1  (dec1),
    .dec2  (dec2),
    .dec3  (dec3),
    .ovf   (ovf),
    .seg   (seg),
    .an    (an),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position in the timeline is just the count of edges since reset.
  int         m_n;
  bit         m_pend;
  bit         m_valid;
  logic [3:0] m_dig [4];
  logic       m_ovf;
  logic [7:0] e_seg;
  logic [3:0] e_an;
  logic       e_frame;

  function automatic logic [7:0] ref_seg(input logic [3:0] d);
    logic [7:0] tbl [10];
    tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    if (d > 4'd9) return 8'h40;
    return tbl[d];
  endfunction

  always @(posedge clk) begin
    int  p, i;
    bit  ld, lead;
    if (reset) begin
      m_n = 0; m_pend = 1'b1; m_valid = 1'b1;
      for (int k = 0; k < 4; k++) m_dig[k] = 4'd0;
      m_ovf = 1'b0;
      e_seg = 8'h00; e_an = 4'd0; e_frame = 1'b0;
    end else begin
      p  = m_n % RD;
      i  = (m_n / RD) % 4;
      ld = m_pend || ((m_n % PERIOD) == PERIOD - 1);
      if (p < GAP) begin
        e_an = 4'd0; e_seg = 8'h00;
      end else begin
        e_an = 4'd0;
        e_an[i] = 1'b1;
        lead = (i > 0);
        for (int k = i; k < 4; k++) if (m_dig[k] != 4'd0) lead = 1'b0;
        if (m_ovf)      e_seg = 8'h40;
        else if (lead)  e_seg = 8'h00;
        else            e_seg = ref_seg(m_dig[i]);
      end
      e_frame = ld;
      if (ld) begin
        m_dig[0] = dec0; m_dig[1] = dec1; m_dig[2] = dec2; m_dig[3] = dec3;
        m_ovf = ovf;
      end
      m_pend = 1'b0;
      m_n++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Every cycle passes through here, so the model comparison runs each cycle.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (m_valid) chk("cycle", {19'd0, seg, an, frame}, {19'd0, e_seg, e_an, e_frame});
  endtask

  task automatic adv_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic rst_load(input logic [3:0] a3, a2, a1, a0, input logic o);
    reset = 1'b1;
    dec3 = a3; dec2 = a2; dec1 = a1; dec0 = a0; ovf = o;
    tick();
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    m_valid = 1'b0;
    reset = 1'b1; dec0 = 0; dec1 = 0; dec2 = 0; dec3 = 0; ovf = 0;
    @(negedge clk);

    // Reset state and first snapshot
    chk("reset_out", {seg, an, frame}, 13'd0);
    rst_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    adv_to(1);  chk("first_frame", frame, 1); chk("first_dark", {seg, an}, 12'h000);
    adv_to(2);  chk("frame_once", frame, 0);
    adv_to(3);  chk("d0", {seg, an}, {8'h66, 4'b0001});
    adv_to(8);  chk("d0_end", {seg, an}, {8'h66, 4'b0001});
    adv_to(9);  chk("gap1", {seg, an}, 12'h000);
    adv_to(11); chk("d1", {seg, an}, {8'h4F, 4'b0010});
    adv_to(19); chk("d2", {seg, an}, {8'h5B, 4'b0100});
    adv_to(27); chk("d3", {seg, an}, {8'h06, 4'b1000});

    // Leading-zero blanking
    rst_load(4'd0, 4'd0, 4'd4, 4'd0, 1'b0);
    adv_to(3);  chk("lz_d0", {seg, an}, {8'h3F, 4'b0001});
    adv_to(11); chk("lz_d1", {seg, an}, {8'h66, 4'b0010});
    adv_to(19); chk("lz_d2", {seg, an}, {8'h00, 4'b0100});
    adv_to(27); chk("lz_d3", {seg, an}, {8'h00, 4'b1000});
    rst_load(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    adv_to(3);  chk("zero_d0", {seg, an}, {8'h3F, 4'b0001});
    adv_to(11); chk("zero_d1", {seg, an}, {8'h00, 4'b0010});

    // Snapshot hold
    rst_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    adv_to(20); dec3 = 4'd5; dec2 = 4'd6; dec1 = 4'd7; dec0 = 4'd8;
    adv_to(35); chk("hold_d0", seg, 8'h66);
    adv_to(63); chk("hold_noframe", frame, 0);
    adv_to(64); chk("hold_frame", frame, 1);
    adv_to(65); chk("hold_frame_end", frame, 0);
    adv_to(67); chk("hold_new_d0", {seg, an}, {8'h7F, 4'b0001});

    // Overflow and illegal digit
    rst_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    adv_to(3);  chk("ovf_d0", seg, 8'h40);
    adv_to(27); chk("ovf_d3", {seg, an}, {8'h40, 4'b1000});
    rst_load(4'd0, 4'd0, 4'd7, 4'hB, 1'b0);
    adv_to(3);  chk("ill_d0", seg, 8'h40);
    adv_to(11); chk("ill_d1", {seg, an}, {8'h07, 4'b0010});

    // Reset mid-scan
    rst_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    adv_to(20); chk("mid_lit", {seg, an}, {8'h5B, 4'b0100});
    reset = 1'b1;
    tick();     chk("mid_reset", {seg, an, frame}, 13'd0);
    reset = 1'b0; cyc = 0;
    adv_to(1);  chk("mid_reframe", {frame, an}, 5'b10000);
    adv_to(3);  chk("mid_restart", {seg, an}, {8'h66, 4'b0001});

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      tick();
      if ($urandom_range(0, 7) == 0) begin
        dec0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dec1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dec2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
        dec3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
        ovf  = ($urandom_range(0, 15) == 0);
      end
      reset = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
